timer_mc: RTL and testbench

- Parametrised multi-channel programmable timer with a simple register bus.
- NCH independent down-counters share one global prescaler tick.
- Each channel runs periodic or one-shot, and raises a one-clock tout pulse plus a sticky status flag on expiry.
- Replaces the fixed 10us/100us two-output timer. It adds programmable width, channel count, mode, interrupt and read-back of live counts.

---
 rtl/timer_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_timer_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_mc.sv
// timer_mc: multi-channel programmable down-counter timer with a register bus.
//
// NCH channels share one prescaler tick. Each channel counts down from LOAD
// on every tick, and on reaching zero emits a one-clk tout pulse and sets
// its sticky STATUS bit. After that it reloads (periodic) or stops (one-shot).
//
// Ports:
//   clk     system clock (1 MHz nominal)
//   rst_n   synchronous active-low reset
//   sel     prescaler rate select: 0 = every clk, 1 = every 2nd clk
//   write   register write strobe (one clk)
//   read    register read strobe (one clk)
//   addr    register address
//   wdata   write data
//   rdata   registered read data; it holds between reads
//   tout    per-channel expiry pulse, one clk wide
//   irq     registered OR over channels of (STATUS & CTRL.ie)
//   pwm_out per-channel compare output (only with TIMER_MC_PWM_EN)
//
// Register map (channel c base = 4*c):
//   +0 CTRL  [0] en, [1] mode (1 = one-shot), [2] ie
//   +1 LOAD
//   +2 COUNT (read-only)
//   +3 CMP when TIMER_MC_PWM_EN is defined, otherwise reserved (reads 0)
//   4*NCH   STATUS (write 1 to clear)
//   4*NCH+1 PRESCALE
//
// Optional feature macro: TIMER_MC_PWM_EN (adds the CMP registers and pwm_out).
module timer_mc #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PRE_W   = 8,
  parameter int unsigned PRE_RST = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [NCH-1:0]    tout,
`ifdef TIMER_MC_PWM_EN
  output logic [NCH-1:0]    pwm_out,
`endif
  output logic              irq
);

  localparam int unsigned CH_W = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(4 * NCH);
  localparam logic [ADDR_W-1:0] PRE_ADDR  = ADDR_W'(4 * NCH + 1);

  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   mode_q;
  logic [NCH-1:0]   ie_q;
  logic [NCH-1:0]   status_q;
  logic [CNT_W-1:0] load_q  [NCH];
  logic [CNT_W-1:0] count_q [NCH];
`ifdef TIMER_MC_PWM_EN
  logic [CNT_W-1:0] cmp_q   [NCH];
  logic [NCH-1:0]   cmp_we;
`endif

  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic             tgl_q;
  logic             adv;
  logic             tick;

  logic [NCH-1:0]    ctrl_we;
  logic [NCH-1:0]    load_we;
  logic              status_we;
  logic              prescale_we;
  logic [NCH-1:0]    w1c;
  logic [NCH-1:0]    expire;
  logic [DATA_W-1:0] rd_val;

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  always_comb begin
    ctrl_we = '0;
    load_we = '0;
`ifdef TIMER_MC_PWM_EN
    cmp_we  = '0;
`endif
    for (int unsigned c = 0; c < NCH; c++) begin
      ctrl_we[c] = write && (addr == ADDR_W'(4 * c));
      load_we[c] = write && (addr == ADDR_W'(4 * c + 1));
`ifdef TIMER_MC_PWM_EN
      cmp_we[c]  = write && (addr == ADDR_W'(4 * c + 3));
`endif
    end
    status_we   = write && (addr == STAT_ADDR);
    prescale_we = write && (addr == PRE_ADDR);
    w1c         = status_we ? wdata[NCH-1:0] : '0;
  end

  // ---------------------------------------------------------------------
  // Prescaler. The toggle flop runs freely, so a sel change only alters
  // which clocks count as advance cycles. pre_cnt is never forced back into
  // range: after PRESCALE is lowered below it, the counter wraps through its
  // maximum to 0.
  // ---------------------------------------------------------------------
  always_comb begin
    adv  = sel ? tgl_q : 1'b1;
    tick = adv && (pre_cnt_q == prescale_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgl_q      <= 1'b0;
      pre_cnt_q  <= '0;
      prescale_q <= PRE_W'(PRE_RST);
    end else begin
      tgl_q <= ~tgl_q;
      if (prescale_we) prescale_q <= wdata[PRE_W-1:0];
      if (adv) pre_cnt_q <= tick ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  always_comb begin
    expire = '0;
    for (int unsigned c = 0; c < NCH; c++)
      expire[c] = tick && en_q[c] && (count_q[c] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= '0;
      mode_q   <= '0;
      ie_q     <= '0;
      status_q <= '0;
      tout     <= '0;
      irq      <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        load_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      tout     <= expire;
      // A set on the same clk as its clear takes priority.
      status_q <= (status_q & ~w1c) | expire;
      irq      <= |(status_q & ie_q);
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ctrl_we[c]) begin
          en_q[c]   <= wdata[0];
          mode_q[c] <= wdata[1];
          ie_q[c]   <= wdata[2];
        end else if (expire[c] && mode_q[c]) begin
          en_q[c] <= 1'b0;
        end

        if (load_we[c]) load_q[c] <= wdata[CNT_W-1:0];

        // A write of en=1 reloads when the channel is stopped, or when a
        // one-shot expiry on the same clk would have stopped it. A CTRL write
        // to a channel that keeps running leaves COUNT untouched.
        if (ctrl_we[c] && wdata[0] && (!en_q[c] || (expire[c] && mode_q[c])))
          count_q[c] <= load_q[c];
        else if (expire[c])
          count_q[c] <= mode_q[c] ? '0 : load_q[c];
        else if (tick && en_q[c])
          count_q[c] <= count_q[c] - CNT_W'(1);
      end
    end
  end

`ifdef TIMER_MC_PWM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out <= '0;
      for (int unsigned c = 0; c < NCH; c++) cmp_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (cmp_we[c]) cmp_q[c] <= wdata[CNT_W-1:0];
        pwm_out[c] <= en_q[c] && (count_q[c] < cmp_q[c]);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    if (addr == STAT_ADDR) begin
      rd_val[NCH-1:0] = status_q;
    end else if (addr == PRE_ADDR) begin
      rd_val[PRE_W-1:0] = prescale_q;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (addr[ADDR_W-1:2] == CH_W'(c)) begin
          case (addr[1:0])
            2'd0:    rd_val[2:0] = {ie_q[c], mode_q[c], en_q[c]};
            2'd1:    rd_val[CNT_W-1:0] = load_q[c];
            2'd2:    rd_val[CNT_W-1:0] = count_q[c];
`ifdef TIMER_MC_PWM_EN
            2'd3:    rd_val[CNT_W-1:0] = cmp_q[c];
`endif
            default: rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    rdata <= '0;
    else if (read) rdata <= rd_val;
  end

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc with the default configuration: NCH=4,
// PRESCALE=9, 1 MHz clock. One time unit is one ns nominal, and CLK is one
// clock period.
module tb_timer_mc;

  localparam int unsigned NCH    = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam longint      CLK    = 1000;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel   = 1'b0;
  logic              write = 1'b0;
  logic              read  = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic [NCH-1:0]    tout;
  logic              irq;
`ifdef TIMER_MC_PWM_EN
  logic [NCH-1:0]    pwm_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  timer_mc #(
    .NCH(NCH), .CNT_W(16), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .PRE_W(8), .PRE_RST(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .write(write), .read(read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tout(tout),
`ifdef TIMER_MC_PWM_EN
    .pwm_out(pwm_out),
`endif
    .irq(irq)
  );

  always #(CLK / 2) clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    write = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    @(negedge clk);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
    d = rdata;
  endtask

  // Returns at the negedge where tout[ch] is first seen high.
  task automatic wait_tout(input int ch, input int budget, output logic [63:0] t);
    bit found = 1'b0;
    t = '0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (tout[ch]) begin
        found = 1'b1;
        t = $time;
      end
    end
    check($sformatf("tout%0d_seen", ch), 64'(found), 64'd1);
  endtask

  initial begin
    #(CLK * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [63:0] t0, t1, t2, t3, t_en;
    int cnt;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rdata", 64'(rdata), 0);
    check("rst_tout", 64'(tout), 0);
    check("rst_irq", 64'(irq), 0);
    for (int a = 0; a < 32; a++) begin
      bus_rd(ADDR_W'(a), d);
      check($sformatf("rst_rd_%0d", a), 64'(d), (a == 17) ? 64'd9 : 64'd0);
    end

    // Periodic rates at sel=0, PRESCALE=9
    bus_wr(5'd1, 16'd0);
    bus_wr(5'd5, 16'd9);
    bus_wr(5'd9, 16'd4);
    bus_wr(5'd0, 16'd1);
    bus_wr(5'd4, 16'd1);
    bus_wr(5'd8, 16'd1);
    wait_tout(0, 250, t1); wait_tout(0, 250, t2);
    check("ch0_period", t2 - t1, 64'(10 * CLK));
    wait_tout(1, 250, t1); wait_tout(1, 250, t2);
    check("ch1_period", t2 - t1, 64'(100 * CLK));
    wait_tout(2, 250, t1); wait_tout(2, 250, t2);
    check("ch2_period", t2 - t1, 64'(50 * CLK));

    // Half-rate select
    @(negedge clk);
    sel = 1'b1;
    wait_tout(0, 50, t0);
    wait_tout(0, 50, t1); wait_tout(0, 50, t2);
    check("ch0_half_rate", t2 - t1, 64'(20 * CLK));
    @(negedge clk);
    sel = 1'b0;

    // One-shot on ch3
    bus_wr(5'd13, 16'd3);
    bus_wr(5'd12, 16'd3);
    t_en = $time;
    wait_tout(3, 60, t1);
    check("oneshot_delay_ok",
          64'((t1 - t_en >= 64'(30 * CLK)) && (t1 - t_en <= 64'(50 * CLK))), 64'd1);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tout[3]) cnt++;
    end
    check("oneshot_extra_pulses", 64'(cnt), 0);
    bus_rd(5'd12, d); check("oneshot_ctrl", 64'(d), 64'h2);
    bus_rd(5'd14, d); check("oneshot_count", 64'(d), 0);

    // Status and irq: only ch1 left running
    bus_wr(5'd0, 16'd0);
    bus_wr(5'd8, 16'd0);
    wait_tout(1, 150, t0);
    bus_wr(5'd16, 16'hF);
    bus_rd(5'd16, d); check("status_cleared", 64'(d), 0);
    bus_wr(5'd4, 16'h5);
    wait_tout(1, 150, t1);
    check("irq_not_yet", 64'(irq), 0);
    @(negedge clk);
    check("irq_set", 64'(irq), 1);
    // Negedge 1 after expiry; W1C commits on the edge after negedge 2.
    bus_wr(5'd16, 16'h2);
    check("irq_hold_after_clr", 64'(irq), 1);
    @(negedge clk);
    check("irq_cleared", 64'(irq), 0);
    // Negedge 4; next expiry edge lies between negedges 99 and 100.
    repeat (95) @(negedge clk);
    write = 1'b1; addr = 5'd16; wdata = 16'h2;
    @(negedge clk);
    write = 1'b0;
    check("coincident_tout", 64'(tout[1]), 1);
    bus_rd(5'd16, d); check("status_set_wins", 64'(d), 64'h2);
    check("irq_after_set_wins", 64'(irq), 1);

    // Same-cycle read and write returns the old value; unmapped writes are ignored
    @(negedge clk);
    write = 1'b1; read = 1'b1; addr = 5'd9; wdata = 16'd7;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check("rw_same_cycle", 64'(rdata), 64'd4);
    bus_rd(5'd9, d); check("rw_new_value", 64'(d), 64'd7);
    bus_wr(5'd31, 16'hFFFF);
    bus_rd(5'd31, d); check("unmapped_rd", 64'(d), 0);

    // LOAD change while running applies from the next reload
    wait_tout(1, 150, t1);
    bus_wr(5'd5, 16'd4);
    wait_tout(1, 150, t2);
    wait_tout(1, 150, t3);
    check("load_chg_cur_period", t2 - t1, 64'(100 * CLK));
    check("load_chg_next_period", t3 - t2, 64'(50 * CLK));

    // Reset on the edge where ch1 would expire next
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_tout", 64'(tout), 0);
    check("midrst_irq", 64'(irq), 0);
    @(negedge clk);
    check("midrst_tout_next", 64'(tout), 0);
    bus_rd(5'd6, d);  check("midrst_count1", 64'(d), 0);
    bus_rd(5'd4, d);  check("midrst_ctrl1", 64'(d), 0);
    bus_rd(5'd16, d); check("midrst_status", 64'(d), 0);
    bus_rd(5'd17, d); check("midrst_prescale", 64'(d), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
